spi_master_cfg: RTL and testbench



---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clkgen.sv | 74 +++++++
 rtl/spi_master_cfg.sv | 200 ++++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and width helpers for spi_master_cfg.
package spi_pkg;

  // ss_idx is never narrower than this, even with a single slave line
  localparam int MIN_SS_W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  function automatic int ss_width(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : MIN_SS_W;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period timer and SCLK generator for spi_master_cfg.
// The timer is a down-counter that reloads at zero; every expiry while the
// master is active is a tick. Ticks during SHIFT become alternating
// leading/trailing SCLK edges, reported as one-cycle strobes.
module spi_clkgen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic             i_shift,
  input  logic [DIV_W-1:0] i_div_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_cpol_idle,
  input  logic             i_cpol,
  output logic             o_sclk,
  output logic             o_tick,
  output logic             o_lead_stb,
  output logic             o_trail_stb,
  output logic             o_done
);

  localparam int EC_W = $clog2(2 * DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0] r_cnt;
  logic [EC_W-1:0]  r_edge_cnt;
  logic             r_sclk;
  logic             w_tick;
  logic             w_edge;

  assign w_tick      = i_run && (r_cnt == '0);
  assign w_edge      = w_tick && i_shift;
  assign o_tick      = w_tick;
  assign o_lead_stb  = w_edge && !r_edge_cnt[0];
  assign o_trail_stb = w_edge && r_edge_cnt[0];
  assign o_done      = w_edge && (r_edge_cnt == LAST_EDGE);
  assign o_sclk      = r_sclk;

  // Half-period down-counter: loaded at accept, reloads from the latched divider at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_start)
      r_cnt <= i_div_load;
    else if (i_run)
      r_cnt <= (r_cnt == '0) ? i_div : r_cnt - 1'b1;
  end

  // Count SCLK edges within SHIFT; even count means the next edge is leading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_edge_cnt <= '0;
    else if (i_start)
      r_edge_cnt <= '0;
    else if (w_edge)
      r_edge_cnt <= r_edge_cnt + 1'b1;
  end

  // SCLK follows the live cpol input while idle, toggles on strobes otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sclk <= 1'b0;
    else if (!i_run)
      r_sclk <= i_cpol_idle;
    else if (o_lead_stb)
      r_sclk <= !i_cpol;
    else if (o_trail_stb)
      r_sclk <= i_cpol;
  end

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master, configurable word width, SCLK divider,
// CPOL/CPHA mode and one-hot slave select.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input.
//
// state | meaning
// IDLE  | tx_ready high, sclk tracks cpol input, waiting for a word
// SETUP | slave selected, one half-period before the first SCLK edge
// SHIFT | 2*DATA_W SCLK edges, sample/drive per CPHA
// HOLD  | one half-period with sclk at cpol and slave still selected
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_SS = 4,
  parameter  int DIV_W  = 8,
  localparam int SS_W   = ss_width(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [SS_W-1:0]   ss_idx,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] ALL_BITS = BC_W'(DATA_W);

  spi_state_e        r_state;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DIV_W-1:0]  r_div;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_mosi;
  logic [NUM_SS-1:0] r_ss_n;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_tx_ready;
  logic              r_busy;

  logic              w_accept;
  logic              w_tick;
  logic              w_lead;
  logic              w_trail;
  logic              w_done;
  logic              w_sample;
  logic              w_drive;
  logic [NUM_SS-1:0] w_ss_sel;
  logic [DATA_W-1:0] w_tx_word;
  logic [DATA_W-1:0] w_rx_word;

  assign w_accept = (r_state == IDLE) && r_tx_ready && tx_valid;

  // CPHA=0 samples on leading edges; the final trailing edge carries no new bit
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_drive  = r_cpha ? w_lead : (w_trail && (r_bit_cnt != ALL_BITS));

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    for (int i = 0; i < DATA_W; i++)
      bit_rev[i] = d[DATA_W-1-i];
  endfunction

  // LSB-first reuses the MSB-first shifters by reversing the word at both ends
  assign w_tx_word = lsb_first ? bit_rev(tx_data) : tx_data;
  assign w_rx_word = r_lsb ? bit_rev(r_rx_sr) : r_rx_sr;

  // Bit order is frozen at accept like the rest of the configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lsb <= 1'b0;
    else if (w_accept)
      r_lsb <= lsb_first;
  end
`else
  assign w_tx_word = tx_data;
  assign w_rx_word = r_rx_sr;
`endif

  // One-hot active-low select; an out-of-range index selects nothing
  always_comb begin
    w_ss_sel = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (int'(ss_idx) == i) w_ss_sel[i] = 1'b0;
  end

  spi_clkgen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_clkgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_accept),
    .i_run       (r_state != IDLE),
    .i_shift     (r_state == SHIFT),
    .i_div_load  (clk_div),
    .i_div       (r_div),
    .i_cpol_idle (cpol),
    .i_cpol      (r_cpol),
    .o_sclk      (sclk),
    .o_tick      (w_tick),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail),
    .o_done      (w_done)
  );

  // Transfer sequencer with registered handshake, select and data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_bit_cnt  <= '0;
      r_div      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= '1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= SETUP;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_div      <= clk_div;
            r_cpol     <= cpol;
            r_cpha     <= cpha;
            r_ss_n     <= w_ss_sel;
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            if (!cpha) begin
              // first bit must be on the wire before the first leading edge
              r_mosi  <= w_tx_word[DATA_W-1];
              r_tx_sr <= {w_tx_word[DATA_W-2:0], 1'b0};
            end else begin
              r_tx_sr <= w_tx_word;
            end
          end else begin
            r_tx_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (w_tick) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_sample) begin
            r_rx_sr   <= {r_rx_sr[DATA_W-2:0], miso};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_drive) begin
            r_mosi  <= r_tx_sr[DATA_W-1];
            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
          end
          if (w_done) r_state <= HOLD;
        end
        HOLD: begin
          if (w_tick) begin
            r_state    <= IDLE;
            r_ss_n     <= '1;
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign mosi     = r_mosi;
  assign ss_n     = r_ss_n;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: self-checking bench for spi_master_cfg with a
// behavioural SPI slave that watches sclk and serves/collects bits.
module tb_spi_master_cfg;

  localparam int W      = 8;
  localparam int NUM_SS = 4;
  localparam int DIV_W  = 8;
`ifdef SPI_LSB_FIRST_EN
  localparam bit HAS_LSB = 1'b1;
`else
  localparam bit HAS_LSB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W-1:0]      tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [1:0]        ss_idx = '0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;
  logic [W-1:0]      rx_data;
  logic              rx_valid;
  logic              busy;

  bit   loop = 1'b0;
  bit   lsb_sel = 1'b0;
  logic s_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  assign miso = loop ? mosi : s_miso;

  always #5 clk = ~clk;

  spi_master_cfg #(
    .DATA_W (W),
    .NUM_SS (NUM_SS),
    .DIV_W  (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ss_idx    (ss_idx),
    .clk_div   (clk_div),
    .cpol      (cpol),
    .cpha      (cpha),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_sel),
`endif
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss_n      (ss_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy)
  );

  // One transfer against the slave model. Half-period h = div+1; the word
  // takes (2W+2)*h cycles after the accept edge, so rx_valid is seen at the
  // (2W+2)*h+1-th sample after the accept sample. abort_t>0 pulls reset then.
  task automatic do_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw,
                         input int idx, input int div, input bit pol,
                         input bit pha, input bit lp, input bit lsbf,
                         input int abort_t);
    int h, n, k, wt, rx_seen, rx_t, edge_err, ss_err, st_err, drv_i, cap_i;
    logic [W-1:0] cap, rx_val, exp_rx;
    logic [NUM_SS-1:0] exp_ss;
    logic prev;
    bit lead;
    h = div + 1;
    n = (2 * W + 2) * h;
    exp_ss = '1;
    exp_ss[idx] = 1'b0;
    exp_rx = lp ? tx : sw;
    k = 0; rx_seen = 0; rx_t = -1; edge_err = 0; ss_err = 0; st_err = 0;
    drv_i = 0; cap_i = 0; cap = '0; rx_val = '0;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = tx; ss_idx = 2'(idx); clk_div = DIV_W'(div);
    cpol = pol; cpha = pha; loop = lp; lsb_sel = lsbf;
    if (!pha) begin
      s_miso = lsbf ? sw[0] : sw[W-1];
      drv_i = 1;
    end
    wt = 0;
    do begin @(negedge clk); wt++; end while (!tx_ready && wt < 40);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: tx_ready=%b required 1", tx_ready);
    end
    checks++;
    if (sclk !== pol) begin
      errors++; $display("FAIL idle_sclk_before: sclk=%b required %b", sclk, pol);
    end
    prev = sclk;
    tx_valid = 1'b1;
    for (int t = 1; t <= n + 3; t++) begin
      @(negedge clk);
      if (t == 1) begin
        tx_valid = 1'b0;
        tx_data = W'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        clk_div = DIV_W'($urandom); ss_idx = 2'($urandom);
      end
      if (rx_valid === 1'b1) begin
        rx_seen++; rx_t = t; rx_val = rx_data;
      end
      if (t <= n) begin
        if (ss_n !== exp_ss) ss_err++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) st_err++;
      end else if (t == n + 1) begin
        if (ss_n !== '1) ss_err++;
        if (busy !== 1'b0 || tx_ready !== 1'b0 || sclk !== pol) st_err++;
        tx_data = tx; cpol = pol; cpha = pha; clk_div = DIV_W'(div); ss_idx = 2'(idx);
      end else if (t == n + 2) begin
        if (tx_ready !== 1'b1 || sclk !== pol) st_err++;
      end
      if (sclk !== prev) begin
        lead = (k % 2 == 0);
        if (t != 2 * h + 1 + k * h || sclk !== (lead ? !pol : pol)) edge_err++;
        if (lead != pha) begin
          if (cap_i < W) begin
            if (lsbf) cap[cap_i] = mosi; else cap[W-1-cap_i] = mosi;
          end
          cap_i++;
        end else begin
          if (drv_i < W) s_miso = lsbf ? sw[drv_i] : sw[W-1-drv_i];
          drv_i++;
        end
        k++;
      end
      prev = sclk;
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ss_n, sclk, busy, rx_valid, tx_ready} !== {{NUM_SS{1'b1}}, 4'b0000}) begin
          errors++;
          $display("FAIL abort_outputs: ss_n=%b sclk=%b busy=%b rx_valid=%b tx_ready=%b required ss_n=1111 others 0",
                   ss_n, sclk, busy, rx_valid, tx_ready);
        end
        repeat (3) begin
          @(negedge clk);
          if (rx_valid !== 1'b0) rx_seen++;
        end
        checks++;
        if (rx_seen != 0) begin
          errors++; $display("FAIL abort_no_rx: rx_valid pulses=%0d required 0", rx_seen);
        end
        rst_n = 1'b1;
        return;
      end
    end
    checks++;
    if (rx_seen != 1) begin
      errors++; $display("FAIL rx_pulses: count=%0d required 1", rx_seen);
    end
    checks++;
    if (rx_t != n + 1) begin
      errors++; $display("FAIL latency: cycles=%0d required %0d", rx_t, n + 1);
    end
    checks++;
    if (rx_val !== exp_rx) begin
      errors++; $display("FAIL rx_data: got %h required %h", rx_val, exp_rx);
    end
    checks++;
    if (cap !== tx || cap_i != W) begin
      errors++; $display("FAIL mosi_bits: slave saw %h (%0d bits) required %h", cap, cap_i, tx);
    end
    checks++;
    if (k != 2 * W) begin
      errors++; $display("FAIL edge_count: got %0d required %0d", k, 2 * W);
    end
    checks++;
    if (edge_err != 0) begin
      errors++; $display("FAIL edge_timing: bad edges=%0d required 0", edge_err);
    end
    checks++;
    if (ss_err != 0) begin
      errors++; $display("FAIL ss_n_window: bad cycles=%0d required 0", ss_err);
    end
    checks++;
    if (st_err != 0) begin
      errors++; $display("FAIL busy_ready_idle: bad cycles=%0d required 0", st_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk, mosi, busy, rx_valid, tx_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: sclk=%b mosi=%b busy=%b rx_valid=%b tx_ready=%b required all 0",
               sclk, mosi, busy, rx_valid, tx_ready);
    end
    checks++;
    if (ss_n !== '1) begin
      errors++; $display("FAIL reset_ss_n: got %b required 1111", ss_n);
    end
    checks++;
    if (rx_data !== '0) begin
      errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL ready_at_release: got %b required 0", tx_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_after_release: tx_ready=%b busy=%b required 1/0", tx_ready, busy);
    end
  endtask

  task automatic test_mode0_loopback();
    do_xfer(8'hA5, 8'h00, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_modes_slave();
    do_xfer(8'hC3, 8'h3C, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    do_xfer(8'hC3, 8'h3C, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_xfer(8'hC3, 8'h3C, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_div_ss();
    do_xfer(W'($urandom), W'($urandom), 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    int t, acc_n, rx_n, rdy_err, wt;
    int acc_t[2];
    int rx_t[2];
    logic [W-1:0] rxv[2];
    bit in_xfer;
    acc_n = 0; rx_n = 0; rdy_err = 0; in_xfer = 1'b0;
    acc_t[0] = -100; acc_t[1] = -100; rx_t[0] = -100; rx_t[1] = -100;
    rxv[0] = '0; rxv[1] = '0;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; clk_div = '0; ss_idx = 2'd0; loop = 1'b1; lsb_sel = 1'b0;
    tx_data = 8'h01;
    wt = 0;
    do begin @(negedge clk); wt++; end while (!tx_ready && wt < 40);
    tx_valid = 1'b1;
    acc_t[0] = 0; acc_n = 1; in_xfer = 1'b1;
    t = 0;
    while (rx_n < 2 && t < 150) begin
      @(negedge clk);
      t++;
      if (acc_n == 1) tx_data = 8'hFF;
      if (acc_n >= 2) tx_valid = 1'b0;
      if (in_xfer && tx_ready !== 1'b0) rdy_err++;
      if (rx_valid === 1'b1) begin
        rx_t[rx_n] = t; rxv[rx_n] = rx_data; rx_n++; in_xfer = 1'b0;
      end else if (!in_xfer && tx_valid && tx_ready === 1'b1 && acc_n < 2) begin
        acc_t[acc_n] = t; acc_n++; in_xfer = 1'b1;
      end
    end
    tx_valid = 1'b0;
    checks++;
    if (rx_n != 2) begin
      errors++; $display("FAIL b2b_count: words=%0d required 2", rx_n);
    end
    checks++;
    if (rxv[0] !== 8'h01 || rxv[1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_data: got %h,%h required 01,ff", rxv[0], rxv[1]);
    end
    checks++;
    if (rx_t[0] - acc_t[0] != (2 * W + 2) + 1) begin
      errors++; $display("FAIL b2b_latency: got %0d required %0d", rx_t[0] - acc_t[0], 2 * W + 3);
    end
    checks++;
    if (acc_t[1] != rx_t[0] + 1) begin
      errors++; $display("FAIL b2b_gap: second accept at %0d required %0d", acc_t[1], rx_t[0] + 1);
    end
    checks++;
    if (rdy_err != 0) begin
      errors++; $display("FAIL b2b_ready_low: bad cycles=%0d required 0", rdy_err);
    end
  endtask

  task automatic test_abort();
    do_xfer(8'h5A, 8'h96, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2 * 1 + 1 + 8 * 1);
    do_xfer(8'h69, 8'h00, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_xfer(W'($urandom), W'($urandom), $urandom_range(0, NUM_SS - 1),
              $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
              HAS_LSB ? 1'($urandom) : 1'b0, 0);
    end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first();
    do_xfer(8'h01, 8'h00, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    do_xfer(8'h35, 8'hB2, 3, 1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required bench to finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes_slave();
    test_div_ss();
    test_back_to_back();
    test_abort();
    test_random();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
